// File: rtl/tinyalu_op_driver.sv
// tinyalu_op_driver: command FIFO feeding the TinyALU start/done protocol,
// returning each result with its operands on a valid/ready channel.
module tinyalu_op_driver #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_a,
  output logic [7:0]  rsp_b,
  output logic [2:0]  rsp_op,
  output logic [15:0] rsp_result,
  output logic        rsp_err,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        alu_reset_n
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE, BUSY, NOP, RSTP, RESP
  } state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push, pop;
  cmd_t          head;
  logic          is_alu, is_rst;

  state_t        state_q;
  logic [CW-1:0] tcnt_q;
  logic [7:0]    alu_a_q, alu_b_q;
  logic [2:0]    alu_op_q;
  logic          alu_start_q, alu_rstn_q;
  logic          rsp_valid_q, rsp_err_q;
  logic [7:0]    rsp_a_q, rsp_b_q;
  logic [2:0]    rsp_op_q;
  logic [15:0]   rsp_res_q;

  assign cmd_ready = (cnt_q != (AW+1)'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == IDLE) && (cnt_q != '0);
  assign head      = mem_q[rd_q];
  assign is_alu    = (head.op == 3'd1) || (head.op == 3'd2) ||
                     (head.op == 3'd3) || (head.op == 3'd4);
  assign is_rst    = (head.op == 3'd7);

  // Occupancy follows push/pop; a pop never frees a slot for a same-cycle push.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO storage, written on push only.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= '{a: cmd_a, b: cmd_b, op: cmd_op};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Operation sequencer with registered ALU and response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tcnt_q      <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_start_q <= 1'b0;
      alu_rstn_q  <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_a_q     <= '0;
      rsp_b_q     <= '0;
      rsp_op_q    <= '0;
      rsp_res_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            alu_a_q <= head.a;
            alu_b_q <= head.b;
            unique case (1'b1)
              is_alu: begin
                alu_op_q    <= head.op;
                alu_start_q <= 1'b1;
                tcnt_q      <= '0;
                state_q     <= BUSY;
              end
              is_rst: begin
                alu_op_q   <= head.op;
                alu_rstn_q <= 1'b0;
                state_q    <= RSTP;
              end
              default: begin
                alu_op_q    <= 3'd0;
                alu_start_q <= 1'b1;
                state_q     <= NOP;
              end
            endcase
          end
        end
        BUSY: begin
          if (alu_done) begin
            rsp_a_q     <= alu_a_q;
            rsp_b_q     <= alu_b_q;
            rsp_op_q    <= alu_op_q;
            rsp_res_q   <= alu_result;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            alu_start_q <= 1'b0;
            state_q     <= RESP;
          end else if (tcnt_q == CW'(TIMEOUT - 1)) begin
            rsp_a_q     <= alu_a_q;
            rsp_b_q     <= alu_b_q;
            rsp_op_q    <= alu_op_q;
            rsp_res_q   <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            alu_start_q <= 1'b0;
            state_q     <= RESP;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        NOP: begin
          alu_start_q <= 1'b0;
          state_q     <= IDLE;
        end
        RSTP: begin
          alu_rstn_q <= 1'b1;
          state_q    <= IDLE;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign alu_start   = alu_start_q;
  assign alu_reset_n = alu_rstn_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_a       = rsp_a_q;
  assign rsp_b       = rsp_b_q;
  assign rsp_op      = rsp_op_q;
  assign rsp_result  = rsp_res_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_tinyalu_op_driver.sv
// tb_tinyalu_op_driver: directed + random commands against a TinyALU model,
// responses scored against an in-order queue of expected results.
module tb_tinyalu_op_driver;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 0;
  logic        reset_n = 0;
  logic        cmd_valid = 0;
  logic        cmd_ready;
  logic [7:0]  cmd_a = 0, cmd_b = 0;
  logic [2:0]  cmd_op = 0;
  logic        rsp_valid;
  logic        rsp_ready = 1;
  logic [7:0]  rsp_a, rsp_b;
  logic [2:0]  rsp_op;
  logic [15:0] rsp_result;
  logic        rsp_err;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done = 0;
  logic [15:0] alu_result = 0;
  logic        alu_reset_n;

  always #5 clk = ~clk;

  tinyalu_op_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_op(rsp_op),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_start(alu_start), .alu_done(alu_done),
    .alu_result(alu_result), .alu_reset_n(alu_reset_n)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic [15:0] res;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   nrsp = 0;
  bit   hang = 0;
  bit   rand_rdy = 0;
  int   mcnt = 0;
  int   run = 0;
  int   pulses = 0;
  int   rstlow = 0;
  int   len_log[$];
  int   op_log[$];

  function automatic logic [15:0] ref_res(logic [7:0] a, logic [7:0] b,
                                          logic [2:0] op);
    case (op)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  // TinyALU model: done one cycle after start (three for mul), unless hung.
  always @(posedge clk) begin
    if (!alu_reset_n || !alu_start) begin
      mcnt = 0;
      alu_done <= 1'b0;
    end else if (alu_done) begin
      alu_done <= 1'b0;
    end else if (!hang) begin
      mcnt++;
      if (mcnt >= ((alu_op == 3'd4) ? 3 : 1)) begin
        alu_done   <= 1'b1;
        alu_result <= ref_res(alu_a, alu_b, alu_op);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // Observe start pulses, ALU reset pulses and scored responses.
  always @(negedge clk) begin
    if (alu_start) begin
      run++;
      if (run == 1) op_log.push_back(int'(alu_op));
    end else if (run > 0) begin
      len_log.push_back(run);
      pulses++;
      run = 0;
    end
    if (!alu_reset_n) rstlow++;
    if (reset_n && rsp_valid && rsp_ready) begin
      nrsp++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL rsp_unexpected got %h/%h/%h/%h/%b expected none",
               rsp_a, rsp_b, rsp_op, rsp_result, rsp_err);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        assert ({rsp_a, rsp_b, rsp_op, rsp_result, rsp_err} ===
                {e.a, e.b, e.op, e.res, e.err}) else begin
          errors++;
          $error("FAIL rsp got %h/%h/%h/%h/%b expected %h/%h/%h/%h/%b",
                 rsp_a, rsp_b, rsp_op, rsp_result, rsp_err,
                 e.a, e.b, e.op, e.res, e.err);
        end
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, input bit ex, input bit er);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("push_timeout", 0, 1);
    end else if (ex) begin
      exp_q.push_back('{a: a, b: b, op: op,
                        res: er ? 16'h0000 : ref_res(a, b, op), err: er});
    end
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_rsp", int'(rsp_valid), 1);
  endtask

  task automatic set_rdy(input logic v);
    @(posedge clk);
    #1 rsp_ready = v;
  endtask

  int p0, n0, r0, o0;
  logic [2:0] rop;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_alu_reset_n", int'(alu_reset_n), 1);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_alu_start", int'(alu_start), 0);
    chk("rst_rsp_result", int'(rsp_result), 0);
    chk("rst_rsp_misc", int'({rsp_a, rsp_b, rsp_op, rsp_err}), 0);
    chk("rst_alu_ops", int'({alu_a, alu_b, alu_op}), 0);
    @(posedge clk);
    #2 reset_n = 1;

    p0 = pulses;
    push(8'hFF, 8'h55, 3'd1, 1, 0);
    drain();
    chk("add_pulses", pulses - p0, 1);

    p0 = pulses;
    n0 = nrsp;
    push(8'hAA, 8'hEE, 3'd3, 1, 0);
    push(8'h0F, 8'h0F, 3'd4, 1, 0);
    drain();
    chk("b2b_pulses", pulses - p0, 2);
    chk("b2b_rsps", nrsp - n0, 2);

    p0 = pulses;
    n0 = nrsp;
    r0 = rstlow;
    o0 = op_log.size();
    push(8'h11, 8'h22, 3'd0, 0, 0);
    push(8'h12, 8'h34, 3'd5, 0, 0);
    push(8'h00, 8'h00, 3'd7, 0, 0);
    push(8'h00, 8'h00, 3'd1, 1, 0);
    drain();
    chk("nop_pulses", pulses - p0, 3);
    chk("nop_len", len_log[p0], 1);
    chk("ill_len", len_log[p0 + 1], 1);
    chk("nop_op", op_log[o0], 0);
    chk("ill_op", op_log[o0 + 1], 0);
    chk("rst_low_cycles", rstlow - r0, 1);
    chk("nop_rsps", nrsp - n0, 1);

    n0 = nrsp;
    set_rdy(0);
    push(8'h01, 8'h01, 3'd1, 1, 0);
    wait_rsp();
    for (int i = 0; i < DEPTH; i++) begin
      push(8'(i * 7 + 3), 8'(i + 40), 3'(i % 4 + 1), 1, 0);
    end
    repeat (2) @(negedge clk);
    chk("full_ready", int'(cmd_ready), 0);
    fork
      push(8'hC3, 8'h3C, 3'd2, 1, 0);
      begin
        repeat (3) @(negedge clk);
        set_rdy(1);
      end
    join
    drain();
    chk("full_rsps", nrsp - n0, DEPTH + 2);

    hang = 1;
    n0 = nrsp;
    p0 = pulses;
    push(8'h01, 8'h02, 3'd1, 1, 1);
    push(8'h03, 8'h05, 3'd3, 1, 0);
    wait_rsp();
    hang = 0;
    drain();
    chk("to_len", len_log[p0], TIMEOUT);
    chk("to_rsps", nrsp - n0, 2);

    n0 = nrsp;
    rand_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      push(8'($urandom), 8'($urandom), rop, (rop >= 3'd1 && rop <= 3'd4), 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rand_rdy = 0;
    repeat (2) @(posedge clk);
    #1 rsp_ready = 1;
    drain();

    set_rdy(0);
    hang = 1;
    push(8'h09, 8'h09, 3'd1, 0, 0);
    push(8'h0A, 8'h0A, 3'd2, 0, 0);
    push(8'h0B, 8'h0B, 3'd3, 0, 0);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", int'(alu_start), 1);
    n0 = nrsp;
    @(posedge clk);
    #2 reset_n = 0;
    #1;
    chk("arst_start", int'(alu_start), 0);
    chk("arst_rsp_valid", int'(rsp_valid), 0);
    chk("arst_cmd_ready", int'(cmd_ready), 1);
    hang = 0;
    repeat (2) @(negedge clk);
    p0 = pulses;
    set_rdy(1);
    @(posedge clk);
    #2 reset_n = 1;
    repeat (40) @(negedge clk);
    chk("post_rst_pulses", pulses - p0, 0);
    chk("post_rst_rsps", nrsp - n0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
